enc_block_loader: RTL and testbench

Byte-stream front end and result buffer for the 64-bit-block / 80-bit-key `Test_Encrypt` round core. It assembles key and plaintext bytes from a valid/ready byte stream and holds the core in reset while loading. It then releases the core, captures the ciphertext once the final round completes, and presents it on a 64-bit valid/ready output. It sits directly upstream of the core's `orig_key`/`plaintext`/`rst` inputs and directly downstream of its `ciphertext`/`done` outputs.

---
 rtl/enc_block_loader_pkg.sv | 19 +
 rtl/enc_block_loader_byte_packer.sv | 33 +++
 rtl/enc_block_loader.sv | 106 ++++++++++
 tb/tb_enc_block_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/enc_block_loader_pkg.sv
// Shared sizes and FSM state type for the
// encrypt-core byte loader.
package enc_block_loader_pkg;

  localparam int SIZE      = 64;
  localparam int KEY_SIZE  = 80;
  localparam int KEY_BYTES = KEY_SIZE / 8;
  localparam int BLK_BYTES = SIZE / 8;
  localparam int ENC_LAT   = 34;

  typedef enum logic [2:0] {
    LOAD,
    START,
    RUN,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/enc_block_loader_byte_packer.sv
// MSB-first byte shift register with a byte
// counter; full pulses on the last byte.
module byte_packer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [7:0]   din,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int N  = W / 8;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;

  assign full = en && (cnt == LAST);

  // shift in one byte per accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (en) begin
      word <= {word[W-9:0], din};
      cnt  <= full ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/enc_block_loader.sv
// Byte-stream loader and ciphertext buffer
// around the 64/80-bit encrypt round core.
module enc_block_loader
  import enc_block_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_is_key,
  output logic [KEY_SIZE-1:0] core_key,
  output logic [SIZE-1:0]     core_pt,
  output logic                core_rst,
  input  logic                core_done,
  input  logic [SIZE-1:0]     core_ct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     out_data
);

  state_t state, state_nxt;

  logic                acc;
  logic                key_en;
  logic                pt_en;
  logic                key_full;
  logic                key_full_q;
  logic                pt_full;
  logic [KEY_SIZE-1:0] key_word;

  assign in_ready = (state == LOAD) && rst;
  assign acc      = in_valid && in_ready;
  assign key_en   = acc && in_is_key;
  assign pt_en    = acc && !in_is_key;

  byte_packer #(.W(KEY_SIZE)) u_key (
    .clk  (clk),
    .rst  (rst),
    .en   (key_en),
    .din  (in_data),
    .word (key_word),
    .full (key_full)
  );

  byte_packer #(.W(SIZE)) u_pt (
    .clk  (clk),
    .rst  (rst),
    .en   (pt_en),
    .din  (in_data),
    .word (core_pt),
    .full (pt_full)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (pt_full)   state_nxt = START;
      START:                  state_nxt = RUN;
      RUN:     if (core_done) state_nxt = CAPTURE;
      CAPTURE:                state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = LOAD;
      default:                state_nxt = LOAD;
    endcase
  end

  // commit a whole key once the shadow is full;
  // the core samples it no earlier than 9 edges on
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_full_q <= 1'b0;
      core_key   <= '0;
    end else begin
      key_full_q <= key_full;
      if (key_full_q) core_key <= key_word;
    end
  end

  // core runs only in RUN and CAPTURE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) core_rst <= 1'b0;
    else      core_rst <= (state_nxt == RUN) ||
                          (state_nxt == CAPTURE);
  end

  // ciphertext capture and output handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == CAPTURE) begin
      out_valid <= 1'b1;
      out_data  <= core_ct;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc_block_loader.sv
// Directed bench for enc_block_loader with a
// cycle-accurate stand-in for the round core.
module tb_enc_block_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_is_key = 1'b0;
  logic [79:0] core_key;
  logic [63:0] core_pt;
  logic        core_rst;
  logic        core_done;
  logic [63:0] core_ct;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;

  int ntot  = 0;
  int npass = 0;
  int cyc   = 0;
  int last_edge = 0;

  enc_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_is_key (in_is_key),
    .core_key  (core_key),
    .core_pt   (core_pt),
    .core_rst  (core_rst),
    .core_done (core_done),
    .core_ct   (core_ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in cipher: real test vectors for the
  // all-zero and all-one cases, a mix otherwise
  function automatic logic [63:0] ct_fn(
    input logic [79:0] k, input logic [63:0] p);
    if (k == '0 && p == '0)
      return 64'h5579C1387B228445;
    if (k == '1 && p == '1)
      return 64'h3333DCD3213210D2;
    return p ^ k[79:16] ^ 64'h0F1E2D3C4B5A6978;
  endfunction

  // core model: loads while in reset, done high
  // for the 32nd cycle, ct final after done
  logic [5:0]  ccnt;
  logic [79:0] m_key;
  logic [63:0] m_pt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccnt <= '0;
    end else if (!core_rst) begin
      ccnt  <= '0;
      m_key <= core_key;
      m_pt  <= core_pt;
    end else if (ccnt != 6'd63) begin
      ccnt <= ccnt + 6'd1;
    end
  end
  assign core_done = core_rst && (ccnt == 6'd31);
  assign core_ct = (ccnt >= 6'd32) ? ct_fn(m_key, m_pt)
                                   : 64'hBAD0BAD0BAD0BAD0;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic k);
    int w;
    in_valid  = 1'b1;
    in_data   = b;
    in_is_key = k;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_wait", 80'(in_ready), 80'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    last_edge = cyc;
  endtask

  typedef struct {
    logic [7:0]  kb;
    int          nk;
    logic [7:0]  pb;
    int          hold;
    logic [79:0] ekey;
    logic [63:0] ect;
  } vec_t;

  vec_t tv[5];

  task automatic run_block(input vec_t v);
    int lat;
    for (int i = 0; i < v.nk; i++) send(v.kb, 1'b1);
    for (int i = 0; i < 8; i++) send(v.pb, 1'b0);
    chk("start_core_rst", 80'(core_rst), 80'd0);
    chk("start_in_ready", 80'(in_ready), 80'd0);
    @(negedge clk);
    chk("run_core_rst", 80'(core_rst), 80'd1);
    for (int i = 0; i < 100 && !out_valid; i++)
      @(negedge clk);
    lat = cyc - last_edge;
    chk("out_valid", 80'(out_valid), 80'd1);
    chk("latency", 80'(lat), 80'd34);
    chk("out_data", 80'(out_data), 80'(v.ect));
    chk("core_key", core_key, v.ekey);
    chk("core_pt", 80'(core_pt), 80'({8{v.pb}}));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_data", 80'(out_data), 80'(v.ect));
      chk("hold_in_ready", 80'(in_ready), 80'd0);
    end
    chk("hold_valid", 80'(out_valid), 80'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", 80'(out_valid), 80'd0);
    chk("drain_in_ready", 80'(in_ready), 80'd1);
  endtask

  initial begin
    int seen;
    tv[0] = '{8'h00, 10, 8'h00, 0, 80'h0,
              64'h5579C1387B228445};
    tv[1] = '{8'hFF, 10, 8'hFF, 20, {10{8'hFF}},
              64'h3333DCD3213210D2};
    tv[2] = '{8'h5A, 10, 8'h3C, 3, {10{8'h5A}},
              ct_fn({10{8'h5A}}, {8{8'h3C}})};
    tv[3] = '{8'hAA, 4, 8'h11, 0, {10{8'h5A}},
              ct_fn({10{8'h5A}}, {8{8'h11}})};
    tv[4] = '{8'hAA, 6, 8'h22, 0, {10{8'hAA}},
              ct_fn({10{8'hAA}}, {8{8'h22}})};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_core_rst", 80'(core_rst), 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_out_data", 80'(out_data), 80'd0);
    chk("rst_core_key", core_key, 80'd0);
    chk("rst_core_pt", 80'(core_pt), 80'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 80'(in_ready), 80'd1);

    for (int i = 0; i < 5; i++) run_block(tv[i]);

    for (int i = 0; i < 10; i++) send(8'h33, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h44, 1'b0);
    repeat (16) @(negedge clk);
    chk("mid_run_core_rst", 80'(core_rst), 80'd1);
    rst = 1'b0;
    #1;
    chk("arst_core_rst", 80'(core_rst), 80'd0);
    chk("arst_in_ready", 80'(in_ready), 80'd0);
    chk("arst_out_valid", 80'(out_valid), 80'd0);
    chk("arst_core_key", core_key, 80'd0);
    chk("arst_core_pt", 80'(core_pt), 80'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    chk("arst_idle", 80'(seen), 80'd0);
    run_block(tv[0]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
